// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the EX-stage divide handshake.
// Returns {remainder, quotient} with a one-cycle success pulse; signed or unsigned.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     dividend_i,
  input  logic [DATA_W-1:0]     divider_i,
  input  logic                  start_i,
  input  logic                  cancel_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  success_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] divisor;
  logic              quo_neg;
  logic              rem_neg;

  logic              accept;
  logic              last;
  logic [DATA_W:0]   rem_shift;
  logic [DATA_W+1:0] trial;
  logic              borrow;
  logic [DATA_W-1:0] rem_step;
  logic [DATA_W-1:0] quo_step;

  // Two's-complement magnitude; 0x80..0 maps to itself, read back as unsigned.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic             sgn);
    magnitude = (sgn && v[DATA_W-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [DATA_W-1:0] negate_if(input logic [DATA_W-1:0] v,
                                                  input logic             neg);
    negate_if = neg ? (~v + 1'b1) : v;
  endfunction

  assign accept = start_i && !cancel_i;
  assign last   = (count == LAST);

  // One restoring step: shift {rem, quo} left, keep the trial difference if no borrow.
  always_comb begin
    rem_shift = {rem, quo[DATA_W-1]};
    trial     = {1'b0, rem_shift} - {2'b00, divisor};
    borrow    = trial[DATA_W+1];
    rem_step  = borrow ? rem_shift[DATA_W-1:0] : trial[DATA_W-1:0];
    quo_step  = {quo[DATA_W-2:0], ~borrow};
  end

  always_comb begin
    state_next = state;
    success_o  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = (divider_i == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cancel_i) begin
          state_next = IDLE;
        end else if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
        success_o  = !cancel_i;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      quo_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      result_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            count   <= '0;
            rem     <= '0;
            quo     <= magnitude(dividend_i, signed_i);
            divisor <= magnitude(divider_i, signed_i);
            quo_neg <= signed_i && (dividend_i[DATA_W-1] ^ divider_i[DATA_W-1]);
            rem_neg <= signed_i && dividend_i[DATA_W-1];
            if (divider_i == '0) begin
              result_o <= '0;
            end
          end
        end
        BUSY: begin
          if (!cancel_i) begin
            rem   <= rem_step;
            quo   <= quo_step;
            count <= count + 1'b1;
            if (last) begin
              result_o <= {negate_if(rem_step, rem_neg), negate_if(quo_step, quo_neg)};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: unsigned/signed divides, divide-by-zero, cancel and async reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divider_i;
  logic        start_i;
  logic        cancel_i;
  logic [63:0] result_o;
  logic        success_o;

  int cmps = 0;
  int errs = 0;

  div_unit #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divider_i  (divider_i),
    .start_i    (start_i),
    .cancel_i   (cancel_i),
    .result_o   (result_o),
    .success_o  (success_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    cmps++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Hold start until success is seen; latency counts edges from the accepting edge (1).
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int n;
    n = 0;
    @(negedge clk);
    signed_i   = sgn;
    dividend_i = a;
    divider_i  = b;
    start_i    = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
      dividend_i = ~a;
      divider_i  = b ^ 32'h5a5a_0001;
    end while (!success_o && n < 100);
    check({tag, " success"}, 64'(success_o), 64'd1);
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " result"}, result_o, exp);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " pulse end"}, 64'(success_o), 64'd0);
    check({tag, " result hold"}, result_o, exp);
  endtask

  initial begin
    int  seen;
    rst        = 1'b0;
    signed_i   = 1'b0;
    dividend_i = '0;
    divider_i  = '0;
    start_i    = 1'b0;
    cancel_i   = 1'b0;
    #3;
    check("reset result", result_o, 64'd0);
    check("reset success", 64'(success_o), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_div("udiv 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    run_div("sdiv -7/2", 1'b1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run_div("sdiv min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);
    run_div("udiv max/1", 1'b0, 32'hFFFF_FFFF, 32'h1, {32'h0, 32'hFFFF_FFFF}, 33);
    run_div("div by zero", 1'b0, 32'd1234, 32'd0, 64'd0, 1);
    run_div("sdiv 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33);

    // Cancel ten iterations in; the previous result must survive.
    run_div("udiv 50/6", 1'b0, 32'd50, 32'd6, {32'd2, 32'd8}, 33);
    @(negedge clk);
    signed_i   = 1'b0;
    dividend_i = 32'd77;
    divider_i  = 32'd5;
    start_i    = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    cancel_i = 1'b1;
    start_i  = 1'b0;
    check("cancel success gated", 64'(success_o), 64'd0);
    @(posedge clk);
    #1;
    cancel_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (success_o) seen++;
    end
    check("cancel no success", 64'(seen), 64'd0);
    check("cancel result kept", result_o, {32'd2, 32'd8});
    run_div("udiv 9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

    // Asynchronous reset between edges while busy.
    @(negedge clk);
    dividend_i = 32'd1000;
    divider_i  = 32'd7;
    start_i    = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async rst result", result_o, 64'd0);
    check("async rst success", 64'(success_o), 64'd0);
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("held rst success", 64'(success_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_div("udiv 1000/10", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
